// File: rtl/serial_operand_shifter.sv
// serial_operand_shifter
//
// Parallel-in, serial-out operand feeder for the serial bit adder.
// Two WIDTH-bit operands are captured in one cycle, then presented
// LSB-first, one bit pair per cycle, with framing strobes so the adder
// can clear its carry on the first bit and close out on the last.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   start      load request, sampled only while ready=1
//   a_in/b_in  operands, captured on an accepted start
//   hold       stall; freezes shifting while high (SHIFT only)
//   ready      idle, will accept start
//   a_bit      current bit of A (shift register LSB)
//   b_bit      current bit of B (shift register LSB)
//   bit_valid  a_bit/b_bit valid this cycle (combinational on hold)
//   first_bit  bit 0 of the frame, qualified by bit_valid
//   last_bit   bit WIDTH-1 of the frame, qualified by bit_valid
//   bit_idx    index of the bit currently presented
//   done       one-cycle pulse after the last bit is consumed
module serial_operand_shifter #(
  parameter  int WIDTH = 8,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             hold,
  output logic             ready,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit,
  output logic [IDXW-1:0]  bit_idx,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [IDXW-1:0]  idx;
  logic             last_idx;

  assign last_idx = (idx == IDXW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!hold && last_idx) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand shift registers and bit index.
  // idx is cleared in DONE so the register already reads 0 when IDLE
  // is re-entered, and it stops at WIDTH-1 rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa  <= '0;
      sb  <= '0;
      idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa  <= a_in;
            sb  <= b_in;
            idx <= '0;
          end
        end
        SHIFT: begin
          if (!hold) begin
            sa <= sa >> 1;
            sb <= sb >> 1;
            if (!last_idx) begin
              idx <= idx + IDXW'(1);
            end
          end
        end
        DONE: begin
          idx <= '0;
        end
        default: begin
          idx <= '0;
        end
      endcase
    end
  end

  // Output decode; only the strobes look at hold.
  always_comb begin
    ready     = 1'b0;
    a_bit     = 1'b0;
    b_bit     = 1'b0;
    bit_valid = 1'b0;
    first_bit = 1'b0;
    last_bit  = 1'b0;
    bit_idx   = '0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
      end
      SHIFT: begin
        a_bit     = sa[0];
        b_bit     = sb[0];
        bit_valid = !hold;
        first_bit = !hold && (idx == '0);
        last_bit  = !hold && last_idx;
        bit_idx   = idx;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/serial_operand_shifter.md
# serial_operand_shifter

Parallel-in, serial-out operand feeder for the serial bit adder datapath. It accepts two WIDTH-bit operands in one cycle and presents them LSB-first, one bit pair per cycle, to the single-bit full adder. Framing strobes let the adder clear its carry on the first bit and close out on the last. The sum shift register on the adder's output consumes the resulting serial stream.

## Interface
- WIDTH, 8: operand width in bits; legal range 2..16.
- IDXW, $clog2(WIDTH): derived local width of the bit index.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  load request; sampled only while ready=1.
- a_in  in  WIDTH  operand A; captured on an accepted start.
- b_in  in  WIDTH  operand B; captured on an accepted start.
- hold  in  1  stall; freezes shifting while high.
- ready  out  1  block is idle and will accept start.
- a_bit  out  1  current bit of A (shift register LSB).
- b_bit  out  1  current bit of B (shift register LSB).
- bit_valid  out  1  a_bit/b_bit valid this cycle; the adder advances only when high.
- first_bit  out  1  bit 0 of the frame; the adder clears carry. Qualified by bit_valid.
- last_bit  out  1  bit WIDTH-1 of the frame. Qualified by bit_valid.
- bit_idx  out  IDXW  index of the bit currently presented.
- done  out  1  one-cycle pulse after the last bit is consumed.

## Operation
- States are IDLE, SHIFT and DONE.
- IDLE
  - ready=1; all other outputs are 0.
  - If start=1: capture a_in and b_in into shift registers sa and sb, clear bit_idx, and go to SHIFT.
- SHIFT
  - a_bit=sa[0], b_bit=sb[0], bit_valid=!hold.
  - first_bit = bit_valid && bit_idx==0.
  - last_bit = bit_valid && bit_idx==WIDTH-1.
  - On each cycle with hold=0: shift sa and sb right (zero fill) and increment bit_idx. If bit_idx==WIDTH-1, go to DONE instead.
  - On cycles with hold=1: sa, sb, bit_idx and state are unchanged, and a_bit/b_bit keep their value.
- DONE
  - done=1 and ready=0 for exactly one cycle, then go to IDLE. hold is ignored.
- start is ignored in SHIFT and DONE. There is no queuing and no error flag.
- bit_idx never exceeds WIDTH-1; there is no wrap within a frame.
- rst=1 at a clock edge forces IDLE from any state, including mid-frame.
  - sa, sb and bit_idx clear to 0.
  - The partial frame is discarded and done is not pulsed.
- rst has priority over start and hold.
- Reset values: ready=1 and every other output 0.

## Timing
- start accepted at edge t: bit 0 is presented during cycle t+1 with first_bit=1.
- With no hold, bit k is presented in cycle t+1+k and last_bit is asserted in cycle t+WIDTH.
- done is asserted in cycle t+WIDTH+1. ready returns in cycle t+WIDTH+2, so the earliest next accept is at that cycle's edge.
- Minimum frame period is WIDTH+2 cycles. Each hold cycle adds exactly one cycle.
- bit_valid, first_bit and last_bit depend combinationally on hold; all other outputs are direct register decodes.
- hold asserted in the same cycle as an accepted start has no effect on the load. hold is only meaningful in SHIFT.

## Test plan
- Basic frame, WIDTH=8: start with a_in=8'hA5, b_in=8'h3C and hold=0 -> across cycles t+1..t+8, a_bit=1,0,1,0,0,1,0,1 and b_bit=0,0,1,1,1,1,0,0. first_bit is high only at t+1, last_bit only at t+8, done only at t+9, ready high again at t+10.
- Hold mid-stream: A=8'hFF, B=8'h00, with hold=1 for 3 cycles while bit_idx=4 -> bit_valid=0 and bit_idx=4 for those 3 cycles. The stream then resumes at bit 4, last_bit lands at t+11 and done at t+12.
- Start while busy: assert start with a_in=8'h11 at bit_idx=3 of an 8'hA5 frame -> the frame completes unchanged and 8'h11 is never loaded.
- Back-to-back: hold start high continuously with a_in alternating 8'h01/8'h80 -> accepts occur every 10 cycles. Frame 1 shows a_bit=1 only at bit 0; frame 2 shows a_bit=1 only at bit 7.
- Reset mid-frame: assert rst at bit_idx=5 -> the next cycle has ready=1, bit_valid=0 and bit_idx=0, and no done pulse occurs. A following start of 8'hC3 frames cleanly from bit 0.
- Parameter check, WIDTH=4: A=4'b1001, B=4'b0110 -> a_bit=1,0,0,1 and b_bit=0,1,1,0, last_bit at t+4 and done at t+5.
